// File: rtl/adder_pkg.sv
// Shared types and constants for the adder family.
package adder_pkg;

   // Controller state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Width of a counter that must reach w-1; never narrower than one bit
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell. The sum and carry are purely combinational;
// clk/reset_n are only used to flag undefined inputs while out of reset.
module full_adder (
   input  logic clk,
   input  logic reset_n,
   input  logic i_a,
   input  logic i_b,
   input  logic i_carry_in,
   output logic o_sum,
   output logic o_carry_out
);

   // Sum is the three-input parity, carry is the majority
   always_comb begin
      o_sum       = i_a ^ i_b ^ i_carry_in;
      o_carry_out = (i_a & i_b) | (i_a & i_carry_in) | (i_b & i_carry_in);
   end

   // Inputs come from reset registers, so they must always be defined
   a_inputs_known: assert property (@(posedge clk) disable iff (!reset_n)
                                    !$isunknown({i_a, i_b, i_carry_in}));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder is reused for WIDTH cycles, LSB first,
// with the carry held in a register between bit positions.
module serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry_out,
   output logic             o_overflow,
   output logic             o_busy
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic             carry_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic             fa_sum;
   logic             fa_cout;

   // The only datapath element: sees the current LSBs and the running carry
   full_adder u_fa (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_a         (a_sh_reg[0]),
      .i_b         (b_sh_reg[0]),
      .i_carry_in  (carry_reg),
      .o_sum       (fa_sum),
      .o_carry_out (fa_cout)
   );

   // Sequencer: handshake, operand/sum shifting, carry and result capture.
   // o_sum doubles as the sum shift register; it fills from the MSB end so
   // that after WIDTH shifts bit 0 of the result sits in o_sum[0].
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         o_ready     <= 1'b1;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_sum       <= '0;
         o_carry_out <= 1'b0;
         o_overflow  <= 1'b0;
         a_sh_reg    <= '0;
         b_sh_reg    <= '0;
         carry_reg   <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  a_sh_reg  <= i_a;
                  b_sh_reg  <= i_b;
                  carry_reg <= i_carry_in;
                  cnt_reg   <= '0;
                  o_ready   <= 1'b0;
                  o_busy    <= 1'b1;
                  state_reg <= RUN;
               end
            end

            RUN: begin
               a_sh_reg  <= a_sh_reg >> 1;
               b_sh_reg  <= b_sh_reg >> 1;
               o_sum     <= {fa_sum, o_sum[WIDTH-1:1]};
               carry_reg <= fa_cout;
               if (cnt_reg == LAST_BIT) begin
                  // carry_reg still holds the carry into the MSB here
                  o_overflow  <= carry_reg ^ fa_cout;
                  o_carry_out <= fa_cout;
                  o_valid     <= 1'b1;
                  state_reg   <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            DONE: begin
               if (i_ready) begin
                  o_valid   <= 1'b0;
                  o_ready   <= 1'b1;
                  o_busy    <= 1'b0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               o_valid   <= 1'b0;
               o_ready   <= 1'b1;
               o_busy    <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
